// File: rtl/sumblock_bist_pkg.sv
// Shared types and helpers for the sumblock BIST controller.
package sumblock_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam int unsigned NUM_VECTORS = 256;
    localparam int unsigned VEC_W       = 8;

    // Golden sum: s_i = p_i ^ c_(i-1), which lines up bitwise as {p1..p4} ^ {c0..c3}.
    function automatic logic [3:0] exp_sum(input logic [3:0] p, input logic [3:0] c);
        return p ^ c;
    endfunction

endpackage

// File: rtl/sumblock_bist_if.sv
// Control/status handshake plus the stimulus/response bus toward the sumblock under test.
interface sumblock_bist_if;
    import sumblock_bist_pkg::*;

    logic             start;
    logic             busy;
    logic             done;
    logic             pass;
    logic [8:0]       err_count;
    logic [VEC_W-1:0] first_fail_vec;
    logic [3:0]       first_fail_got;
    logic             fail_seen;
    logic [3:0]       p_out;
    logic [3:0]       c_out;
    logic [3:0]       s_in;

    // BIST side: receives start and the sums, drives status and stimulus.
    modport slave (
        input  start, s_in,
        output busy, done, pass, err_count, first_fail_vec, first_fail_got,
               fail_seen, p_out, c_out
    );

    // Controller/datapath side.
    modport master (
        output start, s_in,
        input  busy, done, pass, err_count, first_fail_vec, first_fail_got,
               fail_seen, p_out, c_out
    );

endinterface

// File: rtl/sumblock_bist_checker.sv
// Compares the sampled sums against the golden function of the applied vector.
module sumblock_bist_checker
    import sumblock_bist_pkg::*;
(
    input  logic [3:0] p,
    input  logic [3:0] c,
    input  logic [3:0] s_in,
    output logic       mismatch
);

    // Flag any bit of s that disagrees with p ^ c.
    always_comb begin
        mismatch = (s_in != exp_sum(p, c));
    end

endmodule

// File: rtl/sumblock_bist.sv
// Exhaustive self-test controller for the 4-bit CLA sum block.
module sumblock_bist
    import sumblock_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    sumblock_bist_if.slave bus
);

    localparam logic [3:0]       SETTLE_LAST = 4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VECTORS - 1);

    state_t           state;
    state_t           state_nx;
    logic [VEC_W-1:0] vec_idx;
    logic [3:0]       settle_cnt;
    logic [3:0]       p_q;
    logic [3:0]       c_q;
    logic [8:0]       err_q;
    logic [VEC_W-1:0] ffv_q;
    logic [3:0]       ffg_q;
    logic             fail_seen_q;
    logic             mismatch;
    logic             last_vec;

    assign last_vec = (vec_idx == LAST_VEC);

    sumblock_bist_checker u_checker (
        .p        (p_q),
        .c        (c_q),
        .s_in     (bus.s_in),
        .mismatch (mismatch)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE: if (bus.start) state_nx = ST_APPLY;
            ST_APPLY:         state_nx = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
            ST_SETTLE:        if (settle_cnt == SETTLE_LAST) state_nx = ST_CHECK;
            ST_CHECK:         state_nx = last_vec ? ST_DONE : ST_APPLY;
            default:          state_nx = ST_IDLE;
        endcase
    end

    // Vector index, stimulus, settle counter, error count and first-failure capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_idx     <= '0;
            settle_cnt  <= '0;
            p_q         <= '0;
            c_q         <= '0;
            err_q       <= '0;
            ffv_q       <= '0;
            ffg_q       <= '0;
            fail_seen_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        vec_idx     <= '0;
                        err_q       <= '0;
                        ffv_q       <= '0;
                        ffg_q       <= '0;
                        fail_seen_q <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    {p_q, c_q} <= vec_idx;
                    settle_cnt <= '0;
                end
                ST_SETTLE: settle_cnt <= settle_cnt + 4'd1;
                ST_CHECK: begin
                    if (mismatch) begin
                        err_q <= err_q + 9'd1;
                        if (!fail_seen_q) begin
                            ffv_q       <= vec_idx;
                            ffg_q       <= bus.s_in;
                            fail_seen_q <= 1'b1;
                        end
                    end
                    if (!last_vec) vec_idx <= vec_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy           = (state == ST_APPLY) || (state == ST_SETTLE) || (state == ST_CHECK);
    assign bus.done           = (state == ST_DONE);
    assign bus.pass           = (state == ST_DONE) && (err_q == '0);
    assign bus.err_count      = err_q;
    assign bus.first_fail_vec = ffv_q;
    assign bus.first_fail_got = ffg_q;
    assign bus.fail_seen      = fail_seen_q;
    assign bus.p_out          = p_q;
    assign bus.c_out          = c_q;

endmodule

// File: tb/tb_sumblock_bist.sv
// Scoreboard bench for sumblock_bist: stimulus pushes expected run results, monitors check on done.
module tb_sumblock_bist;
    import sumblock_bist_pkg::*;

    typedef struct {
        int         start_cyc;
        int         cycles;
        logic [8:0] err;
        logic       pass;
        logic       fs;
        logic [7:0] ffv;
        logic [3:0] ffg;
        logic [3:0] p;
        logic [3:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sumblock_bist_if b1 ();
    sumblock_bist_if b3 ();
    sumblock_bist_if b0 ();

    sumblock_bist #(.SETTLE_CYCLES(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    sumblock_bist #(.SETTLE_CYCLES(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
    sumblock_bist #(.SETTLE_CYCLES(0)) u0 (.clk(clk), .rst(rst), .bus(b0));

    // 0: healthy, 1: s4 stuck-at-0, 2: s1 inverted
    logic [1:0] fault1;

    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    exp_t q1[$];
    exp_t q3[$];
    exp_t q0[$];

    // Reference sumblock, bit by bit: s1=p1^c0, s2=p2^c1, s3=p3^c2, s4=p4^c3.
    function automatic logic [3:0] ref_sum(input logic [3:0] p, input logic [3:0] c);
        logic [3:0] s;
        s[3] = p[3] ^ c[3];
        s[2] = p[2] ^ c[2];
        s[1] = p[1] ^ c[1];
        s[0] = p[0] ^ c[0];
        return s;
    endfunction

    always_comb begin
        b1.s_in = ref_sum(b1.p_out, b1.c_out);
        if (fault1 == 2'd1)      b1.s_in[0] = 1'b0;
        else if (fault1 == 2'd2) b1.s_in[3] = ~b1.s_in[3];
    end
    always_comb b3.s_in = ref_sum(b3.p_out, b3.c_out);
    always_comb b0.s_in = ref_sum(b0.p_out, b0.c_out);

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got == want) passed++;
        else $display("FAIL %s got=%0d want=%0d", name, got, want);
    endtask

    task automatic check_run(input string tag, input exp_t e, input int now,
                             input logic [8:0] err, input logic pass, input logic fs,
                             input logic [7:0] ffv, input logic [3:0] ffg,
                             input logic [3:0] p, input logic [3:0] c);
        chk({tag, "_cycles"},    now - e.start_cyc, e.cycles);
        chk({tag, "_err_count"}, int'(err), int'(e.err));
        chk({tag, "_pass"},      int'(pass), int'(e.pass));
        chk({tag, "_fail_seen"}, int'(fs), int'(e.fs));
        chk({tag, "_ff_vec"},    int'(ffv), int'(e.ffv));
        chk({tag, "_ff_got"},    int'(ffg), int'(e.ffg));
        chk({tag, "_p_out"},     int'(p), int'(e.p));
        chk({tag, "_c_out"},     int'(c), int'(e.c));
    endtask

    function automatic exp_t mk(input int sc, input int cycles, input logic [8:0] err,
                                input logic pass, input logic fs,
                                input logic [7:0] ffv, input logic [3:0] ffg);
        exp_t e;
        e.start_cyc = sc;
        e.cycles    = cycles;
        e.err       = err;
        e.pass      = pass;
        e.fs        = fs;
        e.ffv       = ffv;
        e.ffg       = ffg;
        e.p         = 4'hF;
        e.c         = 4'hF;
        return e;
    endfunction

    // Monitors: compare against the oldest expectation whenever done rises.
    logic d1_q = 1'b0, d3_q = 1'b0, d0_q = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (b1.done && !d1_q) begin
            if (q1.size() == 0) begin
                total++;
                $display("FAIL u1_unexpected_done got=done want=no_done");
            end else begin
                e = q1.pop_front();
                check_run("u1", e, cyc, b1.err_count, b1.pass, b1.fail_seen,
                          b1.first_fail_vec, b1.first_fail_got, b1.p_out, b1.c_out);
            end
        end
        d1_q = b1.done;
    end

    always @(negedge clk) begin
        exp_t e;
        if (b3.done && !d3_q) begin
            if (q3.size() == 0) begin
                total++;
                $display("FAIL u3_unexpected_done got=done want=no_done");
            end else begin
                e = q3.pop_front();
                check_run("u3", e, cyc, b3.err_count, b3.pass, b3.fail_seen,
                          b3.first_fail_vec, b3.first_fail_got, b3.p_out, b3.c_out);
            end
        end
        d3_q = b3.done;
    end

    always @(negedge clk) begin
        exp_t e;
        if (b0.done && !d0_q) begin
            if (q0.size() == 0) begin
                total++;
                $display("FAIL u0_unexpected_done got=done want=no_done");
            end else begin
                e = q0.pop_front();
                check_run("u0", e, cyc, b0.err_count, b0.pass, b0.fail_seen,
                          b0.first_fail_vec, b0.first_fail_got, b0.p_out, b0.c_out);
            end
        end
        d0_q = b0.done;
    end

    task automatic start_run(input int which, output int sc);
        @(negedge clk);
        case (which)
            1:       b1.start = 1'b1;
            3:       b3.start = 1'b1;
            default: b0.start = 1'b1;
        endcase
        @(posedge clk);
        #1;
        b1.start = 1'b0;
        b3.start = 1'b0;
        b0.start = 1'b0;
        sc = cyc;
    endtask

    task automatic wait_done(input int which, input int budget);
        int   n = 0;
        logic d = 1'b0;
        do begin
            @(negedge clk);
            n++;
            case (which)
                1:       d = b1.done;
                3:       d = b3.done;
                default: d = b0.done;
            endcase
        end while (!d && n < budget);
        if (!d) begin
            total++;
            $display("FAIL wait_done_u%0d got=timeout want=done within %0d cycles", which, budget);
        end
    endtask

    task automatic check_reset_u1(input string tag);
        chk({tag, "_busy"},      int'(b1.busy), 0);
        chk({tag, "_done"},      int'(b1.done), 0);
        chk({tag, "_pass"},      int'(b1.pass), 0);
        chk({tag, "_err_count"}, int'(b1.err_count), 0);
        chk({tag, "_fail_seen"}, int'(b1.fail_seen), 0);
        chk({tag, "_ff_vec"},    int'(b1.first_fail_vec), 0);
        chk({tag, "_ff_got"},    int'(b1.first_fail_got), 0);
        chk({tag, "_p_out"},     int'(b1.p_out), 0);
        chk({tag, "_c_out"},     int'(b1.c_out), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sc;
        rst      = 1'b1;
        fault1   = 2'd0;
        b1.start = 1'b0;
        b3.start = 1'b0;
        b0.start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_u1("reset");
        rst = 1'b0;

        // Healthy run, default settle.
        start_run(1, sc);
        q1.push_back(mk(sc, 768, 9'd0, 1'b1, 1'b0, 8'h00, 4'h0));
        wait_done(1, 1000);

        // s4 stuck-at-0: half the vectors expect s4=1.
        fault1 = 2'd1;
        start_run(1, sc);
        q1.push_back(mk(sc, 768, 9'd128, 1'b0, 1'b1, 8'h01, 4'b0000));
        wait_done(1, 1000);

        // s1 inverted: every vector fails, vector 0 reads 1000.
        fault1 = 2'd2;
        start_run(1, sc);
        q1.push_back(mk(sc, 768, 9'd256, 1'b0, 1'b1, 8'h00, 4'b1000));
        wait_done(1, 1000);

        // start re-pulsed mid-run must not disturb the run.
        fault1 = 2'd0;
        start_run(1, sc);
        q1.push_back(mk(sc, 768, 9'd0, 1'b1, 1'b0, 8'h00, 4'h0));
        repeat (49) @(negedge clk);
        b1.start = 1'b1;
        @(posedge clk);
        #1;
        b1.start = 1'b0;
        chk("repulse_busy", int'(b1.busy), 1);
        wait_done(1, 1000);

        // start in DONE: done drops on the start edge, run repeats identically.
        start_run(1, sc);
        chk("restart_done_drop", int'(b1.done), 0);
        chk("restart_busy", int'(b1.busy), 1);
        q1.push_back(mk(sc, 768, 9'd0, 1'b1, 1'b0, 8'h00, 4'h0));
        wait_done(1, 1000);

        // Asynchronous reset mid-run, checked before the next clock edge.
        start_run(1, sc);
        q1.push_back(mk(sc, 768, 9'd0, 1'b1, 1'b0, 8'h00, 4'h0));
        repeat (99) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_u1("rst_mid");
        void'(q1.pop_back());
        @(negedge clk);
        rst = 1'b0;
        start_run(1, sc);
        q1.push_back(mk(sc, 768, 9'd0, 1'b1, 1'b0, 8'h00, 4'h0));
        wait_done(1, 1000);

        // Settle-length variants.
        start_run(3, sc);
        q3.push_back(mk(sc, 1280, 9'd0, 1'b1, 1'b0, 8'h00, 4'h0));
        wait_done(3, 1600);

        start_run(0, sc);
        q0.push_back(mk(sc, 512, 9'd0, 1'b1, 1'b0, 8'h00, 4'h0));
        wait_done(0, 800);

        repeat (3) @(negedge clk);
        chk("q1_drained", q1.size(), 0);
        chk("q3_drained", q3.size(), 0);
        chk("q0_drained", q0.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
